// File: rtl/alu_pkg.sv
// Shared constants and types for the wide ALU sequencer and the external alu32.
package alu_pkg;

    localparam int WORD_W = 32;

    // alu32 op_code encodings
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_NOR = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_SUB = 4'h5;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_NOR = 3'd2,
        OP_XOR = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5
    } seq_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_wide_sequencer.sv
// Runs 32*WORDS-bit logic/add/sub on a shared 32-bit ALU, one word per cycle, LSW first.
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter  int WORDS = 2,
    localparam int W     = WORD_W * WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      result,
    output logic              carry,
    output logic              overflow,
    output logic              zero,
    output logic              sign,
    output logic              error,
    output logic [3:0]        alu_op_code,
    output logic              alu_forced_add,
    output logic [WORD_W-1:0] alu_data1,
    output logic [WORD_W-1:0] alu_data2,
    output logic [4:0]        alu_shift,
    output logic              alu_carry_in,
    input  logic [WORD_W-1:0] alu_data_out,
    input  logic              alu_carry,
    input  logic              alu_overflow
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t r_state, w_next;

    logic [IDX_W-1:0]              r_idx;
    logic [WORDS-1:0][WORD_W-1:0]  r_a, r_b, r_result;
    logic [2:0]                    r_op;
    logic                          r_chain, r_carry, r_ovf, r_zero, r_err;

    logic w_accept, w_illegal, w_arith, w_sub, w_last;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_illegal = (op > 3'd5);
    assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_sub     = (r_op == OP_SUB);
    assign w_last    = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        alu_op_code    = 4'h0;
        alu_forced_add = 1'b0;
        alu_data1      = '0;
        alu_data2      = '0;
        alu_shift      = 5'd0;
        alu_carry_in   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = w_illegal ? DONE : BUSY;
            end
            BUSY: begin
                alu_data1 = r_a[r_idx];
                if (w_arith) begin
                    // Subtract is a + ~b + 1; the ALU's own subtract is never used.
                    alu_op_code    = ALU_ADD;
                    alu_forced_add = 1'b1;
                    alu_data2      = w_sub ? ~r_b[r_idx] : r_b[r_idx];
                    alu_carry_in   = (r_idx == '0) ? w_sub : r_chain;
                end else begin
                    alu_op_code = {2'b00, r_op[1:0]};
                    alu_data2   = r_b[r_idx];
                end
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 3'd0;
            r_result <= '0;
            r_chain  <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_result <= '0;
            r_chain  <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            // zero starts as the AND-accumulator seed; illegal ops report no flags
            r_zero   <= ~w_illegal;
            r_err    <= w_illegal;
        end else if (r_state == BUSY) begin
            r_result[r_idx] <= alu_data_out;
            r_zero          <= r_zero & (alu_data_out == '0);
            if (w_arith) r_chain <= alu_carry;
            if (w_last) begin
                r_idx   <= '0;
                r_carry <= w_arith & alu_carry;
                r_ovf   <= w_arith & alu_overflow;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign zero     = r_zero & (r_state == DONE);
    assign sign     = r_result[WORDS-1][WORD_W-1];
    assign error    = r_err;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer (WORDS=2) with a behavioural alu32 model.
`timescale 1ns/1ps
module tb_alu_wide_sequencer;
    import alu_pkg::*;

    localparam int WORDS = 2;
    localparam int W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         out_valid, out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry, overflow, zero, sign, error;
    logic [3:0]   alu_op_code;
    logic         alu_forced_add;
    logic [31:0]  alu_data1, alu_data2;
    logic [4:0]   alu_shift;
    logic         alu_carry_in;
    logic [31:0]  alu_data_out;
    logic         alu_carry, alu_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_wide_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .sign(sign), .error(error), .alu_op_code(alu_op_code),
        .alu_forced_add(alu_forced_add), .alu_data1(alu_data1),
        .alu_data2(alu_data2), .alu_shift(alu_shift),
        .alu_carry_in(alu_carry_in), .alu_data_out(alu_data_out),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow)
    );

    // alu32 model: forced_add overrides op_code with data1+data2+carry_in
    logic [32:0] m_sum;
    always_comb begin
        m_sum        = {1'b0, alu_data1} + {1'b0, alu_data2} + {32'd0, alu_carry_in};
        alu_data_out = 32'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        if (alu_forced_add) begin
            alu_data_out = m_sum[31:0];
            alu_carry    = m_sum[32];
            alu_overflow = (alu_data1[31] == alu_data2[31]) && (m_sum[31] != alu_data1[31]);
        end else begin
            case (alu_op_code)
                ALU_AND: alu_data_out = alu_data1 & alu_data2;
                ALU_OR:  alu_data_out = alu_data1 | alu_data2;
                ALU_NOR: alu_data_out = ~(alu_data1 | alu_data2);
                ALU_XOR: alu_data_out = alu_data1 ^ alu_data2;
                default: alu_data_out = 32'd0;
            endcase
        end
    end

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a, b, res;
        logic         c, v, z, s, e;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, " out_valid"}, W'(out_valid), '0);
        chk({nm, " result"}, result, '0);
        chk({nm, " flags"}, W'({carry, overflow, zero, sign, error}), '0);
        chk({nm, " alu drive"}, W'({alu_op_code, alu_forced_add, alu_data1, alu_data2,
                                    alu_shift, alu_carry_in}), '0);
    endtask

    // Accept one op, count edges to out_valid, check results; leaves the DUT in DONE.
    task automatic issue(input vec_t v, output bit ok);
        int n;
        @(negedge clk);
        chk({v.name, " in_ready"}, W'(in_ready), W'(1));
        in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 5));
        n = 0;
        while (!out_valid && n < 20) begin
            if (n == 0) chk({v.name, " shift"}, W'(alu_shift), '0);
            @(posedge clk); #1;
            n++;
        end
        chk({v.name, " latency"}, W'(n), W'(v.lat));
        ok = out_valid;
        chk({v.name, " result"}, result, v.res);
        chk({v.name, " c/v/z/s/e"}, W'({carry, overflow, zero, sign, error}),
            W'({v.c, v.v, v.z, v.s, v.e}));
        chk({v.name, " in_ready in DONE"}, W'(in_ready), '0);
    endtask

    task automatic drain(input string nm);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk({nm, " idle out_valid"}, W'(out_valid), '0);
        chk({nm, " idle in_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        bit ok;
        logic [W-1:0] held;
        logic [4:0]   held_f;

        //        name       op  a                        b                        result                   c    v    z    s    e    lat
        vecs[0]  = '{"add",   3'd4, 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{"sub1",  3'd5, 64'h00000001_00000000, 64'h1, 64'h00000000_FFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[2]  = '{"sub0",  3'd5, 64'h0,                 64'h1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[3]  = '{"addov", 3'd4, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        vecs[4]  = '{"subov", 3'd5, 64'h80000000_00000000, 64'h1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[5]  = '{"xor",   3'd3, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[6]  = '{"ill7",  3'd7, 64'h1234,              64'h5678, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[7]  = '{"and",   3'd0, 64'hF0F0F0F0_0F0F0F0F, 64'hFF00FF00_FF00FF00, 64'hF000F000_0F000F00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[8]  = '{"or",    3'd1, 64'h00000000_00000001, 64'h80000000_00000000, 64'h80000000_00000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[9]  = '{"nor",   3'd2, 64'h0,                 64'h0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[10] = '{"addc",  3'd4, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'h00000000_00000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1 ^ 1'b1, 2};

        #1; check_cleared("reset");
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1; chk("reset in_ready", W'(in_ready), W'(1));

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i], ok);
            drain(vecs[i].name);
        end

        // Backpressure: hold DONE, poke in_valid, results must not move
        issue(vecs[3], ok);
        held = result; held_f = {carry, overflow, zero, sign, error};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 3'd0; a = '1; b = '0;
            @(posedge clk); #1;
            chk("bp result", result, held);
            chk("bp flags", W'({carry, overflow, zero, sign, error}), W'(held_f));
            chk("bp valid/ready", W'({out_valid, in_ready}), W'(2'b10));
        end
        in_valid = 1'b0;
        drain("bp");
        @(posedge clk); #1;
        chk("bp no stray op", W'({out_valid, in_ready}), W'(2'b01));

        // Reset while the top word is in the ALU
        @(negedge clk);
        in_valid = 1'b1; op = 3'd4; a = 64'h7FFFFFFF_FFFFFFFF; b = 64'h1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst mid idx1 drive", W'(alu_forced_add), W'(1));
        rst = 1'b1; #1;
        check_cleared("rst mid");
        @(negedge clk); rst = 1'b0;
        #1; chk("rst mid in_ready", W'(in_ready), W'(1));
        issue(vecs[0], ok);
        drain("post-rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
